adder_result_fifo: RTL and testbench

ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

---
 rtl/adder_result_fifo.sv | 114 +++++++++++
 tb/tb_adder_result_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// adder_result_fifo: circular buffer holding prefix-adder results plus status flags.
// Latency: a push at edge N shows as out_valid in the cycle after N; the head is show-ahead from storage.
// Backpressure: in_ready is low whenever full, regardless of out_ready; out_ready is ignored while empty.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_a, in_b, in_sum captured on a push edge
//   out_valid/out_ready   downstream handshake; out_sum, out_flags show the head entry
//   count                 current occupancy (0..DEPTH)
//   total                 accepted-result counter, saturating at 16'hFFFF
//
// Build option: define ADDER_RESULT_FLAGS_EN to compute and store {carry, overflow, zero}
// per entry. Without it no flag storage exists and out_flags is tied to 3'b000.

module adder_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [31:0]              in_sum,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_sum,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [31:0]   sum_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Status is derived from the occupancy register only, so a full buffer
  // refuses a push even in a cycle where the head is being popped.
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Pointers, occupancy and the accepted counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      total  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && (total != 16'hFFFF)) begin
        total <= total + 16'd1;
      end
    end
  end

  // Storage is not reset; a push coincident with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      sum_mem[wr_ptr] <= in_sum;
    end
  end

  assign out_sum = sum_mem[rd_ptr];

`ifdef ADDER_RESULT_FLAGS_EN
  logic [2:0] flag_mem [DEPTH];
  logic       carry;
  logic       overflow;
  logic       zero;

  // Carry-out shows up as the wrapped sum being smaller than an operand;
  // signed overflow as same-sign operands producing an opposite-sign sum.
  always_comb begin
    carry    = (in_sum < in_a);
    overflow = (in_a[31] == in_b[31]) && (in_sum[31] != in_a[31]);
    zero     = (in_sum == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      flag_mem[wr_ptr] <= {carry, overflow, zero};
    end
  end

  assign out_flags = flag_mem[rd_ptr];
`else
  // Operands only feed the flag logic, which is absent in this build.
  logic unused_operands;
  assign unused_operands = ^{in_a, in_b};
  assign out_flags       = 3'b000;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ADDER_RESULT_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [31:0]   in_sum;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_sum;
  logic [2:0]    out_flags;
  logic [CW-1:0] count;
  logic [15:0]   total;

  adder_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sum    (in_sum),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .count     (count),
    .total     (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: an ordered queue of entries and a saturating counter.
  typedef struct packed {
    logic [31:0] s;
    logic [2:0]  f;
  } ent_t;

  ent_t        q[$];
  int unsigned mtotal = 0;

  function automatic logic [2:0] exp_flags(input logic [31:0] a, input logic [31:0] b);
    longint unsigned usum;
    longint          ssum;
    bit              c;
    bit              o;
    bit              z;
    usum = 64'(a) + 64'(b);
    ssum = longint'($signed(a)) + longint'($signed(b));
    c = (usum > 64'hFFFF_FFFF);
    o = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    z = ((usum % 64'h1_0000_0000) == 64'd0);
    return FLAGS_ON ? {c, o, z} : 3'b000;
  endfunction

  task automatic set_in(input bit v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sum   = a + b;
  endtask

  // Advance one clock; the model applies the rules to the inputs held over the edge.
  task automatic step();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mtotal = 0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.s = in_sum;
        e.f = exp_flags(in_a, in_b);
        q.push_back(e);
        if (mtotal < 65535) mtotal++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 32'd0, 32'd0);
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++; if (count !== CW'(0)) $display("FAIL reset_count: got %0d want 0", count); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
    checks++; if (total !== 16'd0) $display("FAIL reset_total: got %0d want 0", total); else passes++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_in(1'b1, 32'h1, 32'h1);
    step();
    set_in(1'b0, 32'd0, 32'd0);
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_sum !== 32'h2) $display("FAIL basic_out_sum: got %h want 00000002", out_sum); else passes++;
    checks++; if (out_flags !== 3'b000) $display("FAIL basic_out_flags: got %b want 000", out_flags); else passes++;
    checks++; if (count !== CW'(1)) $display("FAIL basic_count: got %0d want 1", count); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_empty: got %b want 0", out_valid); else passes++;
    checks++; if (total !== 16'd1) $display("FAIL basic_total: got %0d want 1", total); else passes++;
  endtask

  task automatic test_flags();
    logic [2:0] want;
    out_ready = 1'b0;
    set_in(1'b1, 32'hFFFF_FFFF, 32'h1);
    step();
    set_in(1'b1, 32'h7FFF_FFFF, 32'h1);
    want = FLAGS_ON ? 3'b101 : 3'b000;
    checks++; if (out_sum !== 32'h0) $display("FAIL flags_carry_sum: got %h want 00000000", out_sum); else passes++;
    checks++; if (out_flags !== want) $display("FAIL flags_carry_zero: got %b want %b", out_flags, want); else passes++;
    out_ready = 1'b1;
    step();
    set_in(1'b0, 32'd0, 32'd0);
    want = FLAGS_ON ? 3'b010 : 3'b000;
    checks++; if (out_sum !== 32'h8000_0000) $display("FAIL flags_ovf_sum: got %h want 80000000", out_sum); else passes++;
    checks++; if (out_flags !== want) $display("FAIL flags_overflow: got %b want %b", out_flags, want); else passes++;
    checks++; if (count !== CW'(1)) $display("FAIL flags_count: got %0d want 1", count); else passes++;
    step();
    checks++; if (count !== CW'(0)) $display("FAIL flags_drain: got %0d want 0", count); else passes++;
  endtask

  task automatic test_fill();
    logic [31:0] got[$];
    int          acc_cyc;
    bit          acc;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 32'd0, 32'(i));
      step();
    end
    checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready_full: got %b want 0", in_ready); else passes++;
    checks++; if (count !== CW'(4)) $display("FAIL fill_count_full: got %0d want 4", count); else passes++;
    set_in(1'b1, 32'd0, 32'd5);
    step();
    checks++; if (count !== CW'(4)) $display("FAIL fill_fifth_held: got %0d want 4", count); else passes++;
    out_ready = 1'b1;
    acc_cyc = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (out_valid) got.push_back(out_sum);
      if (cyc == 0) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL fill_full_pop_refuse: got %b want 0", in_ready); else passes++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        acc_cyc = cyc;
        set_in(1'b0, 32'd0, 32'd0);
      end
      if (!out_valid && !in_valid) break;
    end
    checks++; if (got.size() !== 5) $display("FAIL fill_pop_count: got %0d want 5", got.size()); else passes++;
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== 32'(i + 1)) $display("FAIL fill_order[%0d]: got %0d want %0d", i, got[i], i + 1); else passes++;
      end
    end
    checks++; if (acc_cyc !== 1) $display("FAIL fill_fifth_accept_cycle: got %0d want 1", acc_cyc); else passes++;
    set_in(1'b0, 32'd0, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, $urandom, $urandom);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, $urandom, $urandom);
      checks++; if (count !== CW'(2)) $display("FAIL b2b_count[%0d]: got %0d want 2", i, count); else passes++;
      checks++; if (out_sum !== q[0].s) $display("FAIL b2b_sum[%0d]: got %h want %h", i, out_sum, q[0].s); else passes++;
      checks++; if (out_flags !== q[0].f) $display("FAIL b2b_flags[%0d]: got %b want %b", i, out_flags, q[0].f); else passes++;
      step();
    end
    set_in(1'b0, 32'd0, 32'd0);
    checks++; if (count !== CW'(2)) $display("FAIL b2b_count_end: got %0d want 2", count); else passes++;
    step();
    checks++; if (out_sum !== q[0].s) $display("FAIL b2b_tail_sum: got %h want %h", out_sum, q[0].s); else passes++;
    step();
    checks++; if (count !== CW'(0)) $display("FAIL b2b_drain: got %0d want 0", count); else passes++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(i), 32'd100);
      step();
    end
    checks++; if (count !== CW'(3)) $display("FAIL rstmid_count_before: got %0d want 3", count); else passes++;
    rst = 1'b1;
    set_in(1'b1, 32'h55, 32'h1);
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    set_in(1'b0, 32'd0, 32'd0);
    out_ready = 1'b0;
    checks++; if (count !== CW'(0)) $display("FAIL rstmid_count: got %0d want 0", count); else passes++;
    checks++; if (total !== 16'd0) $display("FAIL rstmid_total: got %0d want 0", total); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else passes++;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    bit acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_valid && ($urandom_range(0, 99) < 60)) set_in(1'b1, pick_operand(), pick_operand());
      out_ready = ($urandom_range(0, 99) < 45);
      checks++; if (count !== CW'(q.size())) $display("FAIL rand_count[%0d]: got %0d want %0d", cyc, count, q.size()); else passes++;
      checks++; if (in_ready !== (q.size() < DEPTH)) $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, in_ready, q.size() < DEPTH); else passes++;
      checks++; if (out_valid !== (q.size() > 0)) $display("FAIL rand_out_valid[%0d]: got %b want %b", cyc, out_valid, q.size() > 0); else passes++;
      checks++; if (total !== 16'(mtotal)) $display("FAIL rand_total[%0d]: got %0d want %0d", cyc, total, mtotal); else passes++;
      if (q.size() > 0) begin
        checks++; if (out_sum !== q[0].s) $display("FAIL rand_sum[%0d]: got %h want %h", cyc, out_sum, q[0].s); else passes++;
        checks++; if (out_flags !== q[0].f) $display("FAIL rand_flags[%0d]: got %b want %b", cyc, out_flags, q[0].f); else passes++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) set_in(1'b0, 32'd0, 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    set_in(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_flags();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
